sync_fifo_stream_reader: RTL and testbench

- Read-side companion to the team's sync FIFO. It drains the FIFO's rd_en/dout/empty interface, whose read data arrives a fixed number of cycles after rd_en, and presents it as a valid/ready stream.
- It absorbs the FIFO read latency with a credit-tracked in-flight pipe and a small skid buffer, so throughput is one word per cycle under any backpressure pattern.
- Sits between any sync FIFO instance and a downstream stream consumer.

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/stream_skid_buffer.sv | 63 ++++++
 rtl/sync_fifo_stream_reader.sv | 81 ++++++++
 tb/tb_sync_fifo_stream_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync FIFO family: legal read-latency range and
// the skid-buffer depth rule used by the stream reader.
package sync_fifo_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // One entry per in-flight read plus two, so a full pipe never blocks a pop.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Circular register buffer with occupancy count; the head entry and level are
// registered so the stream side sees clean, glitch-free outputs.
module stream_skid_buffer
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8,
    localparam int LVL_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [LVL_W-1:0]      level_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal gets its default before any branch, so no latch can be inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: storage is reset too, so the data output reads zero out of reset instead of X.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Drains a fixed-latency sync FIFO read port into a valid/ready stream at one
// word per cycle, using read credits so the skid buffer can never overflow.
module sync_fifo_stream_reader
    import sync_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  RD_LATENCY = 2,
    parameter bit  DEBUG      = 1'b0,
    localparam int BUF_DEPTH  = buf_depth(RD_LATENCY),
    localparam int LVL_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LVL_W-1:0]      buf_level
);

    localparam int CNT_W  = $clog2(RD_LATENCY + 1);
    localparam int USED_W = LVL_W + 1;

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $fatal(1, "sync_fifo_stream_reader: RD_LATENCY out of range");
    end

    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [USED_W-1:0]     used;
    logic                  land;
    logic                  pop;

    assign land = pipe_q[RD_LATENCY-1];
    assign pop  = m_valid && m_ready;
    assign used = USED_W'(inflight_q) + USED_W'(buf_level);

    // Credit check depends only on registered state and fifo_empty; m_ready never reaches it.
    assign fifo_rd_en = arst_n && !fifo_empty && (used < USED_W'(BUF_DEPTH));

    always_comb begin
        pipe_d     = (pipe_q << 1) | RD_LATENCY'(fifo_rd_en);
        inflight_d = inflight_q + CNT_W'(fifo_rd_en) - CNT_W'(land);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pipe_q     <= '0;
            inflight_q <= '0;
        end else begin
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
        end
    end

    stream_skid_buffer #(
        .DEPTH      (BUF_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .arst_n      (arst_n),
        .push_i      (land),
        .push_data_i (fifo_dout),
        .pop_i       (pop),
        .data_o      (m_data),
        .level_o     (buf_level)
    );

    assign m_valid = (buf_level != '0);

    if (DEBUG) begin : g_debug
        always_ff @(posedge clk) begin
            if (arst_n && land && !pop) begin
                assert (buf_level != LVL_W'(BUF_DEPTH));
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Runs RD_LATENCY = 1, 2 and 4 builds side by side against a timestamped
// queue model of the reader plus an end-to-end order scoreboard.
module tb_sync_fifo_stream_reader;

    localparam int DW = 8;
    localparam int NI = 3;

    typedef struct packed {
        logic [DW-1:0] w;
        int            due;
    } fl_t;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          m_ready;
    int            push_n;
    logic [DW-1:0] push_val;
    logic          stat_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    int            st_rd   [NI];
    int            st_hs   [NI];
    int            st_vc   [NI];
    int            st_fv   [NI];
    int            st_lv   [NI];
    int            st_max  [NI];
    int            st_pend [NI];
    logic [DW-1:0] st_fd   [NI];

    logic [NI-1:0] mv_all, rd_all;
    logic [DW-1:0] md_all  [NI];
    logic [3:0]    lvl_all [NI];

    int exp_lat   [NI] = '{2, 3, 5};
    int exp_depth [NI] = '{3, 4, 6};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_lat
        localparam int LAT   = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        localparam int DEPTH = LAT + 2;
        localparam int LW    = $clog2(DEPTH + 1);

        logic [DW-1:0] fifo_dout, m_data;
        logic          fifo_empty, fifo_rd_en, m_valid;
        logic [LW-1:0] buf_level;
        logic          rd_s = 1'b0;

        logic [DW-1:0] fifo_q [$];
        logic [DW-1:0] sent_q [$];
        logic [DW-1:0] mb_q   [$];
        fl_t           fl_q   [$];
        logic [DW-1:0] dpipe  [LAT];

        int            cyc    = 0;
        int            rel    = 0;
        logic          hold_v = 1'b0;
        logic [DW-1:0] hold_d = '0;

        function automatic string nm(input string s);
            return $sformatf("L%0d_%s", LAT, s);
        endfunction

        sync_fifo_stream_reader #(
            .DATA_WIDTH (DW),
            .RD_LATENCY (LAT),
            .DEBUG      (1'b0)
        ) dut (
            .clk        (clk),
            .arst_n     (arst_n),
            .fifo_dout  (fifo_dout),
            .fifo_empty (fifo_empty),
            .fifo_rd_en (fifo_rd_en),
            .m_data     (m_data),
            .m_valid    (m_valid),
            .m_ready    (m_ready),
            .buf_level  (buf_level)
        );

        assign mv_all[gi]  = m_valid;
        assign rd_all[gi]  = fifo_rd_en;
        assign md_all[gi]  = m_data;
        assign lvl_all[gi] = 4'(buf_level);

        // Sync FIFO: a read sampled at an edge shows its word LAT cycles later; junk otherwise.
        initial begin
            fifo_empty = 1'b1;
            fifo_dout  = '0;
            for (int k = 0; k < LAT; k++) dpipe[k] = '0;
            forever begin
                @(posedge clk);
                #2;
                if (!arst_n) begin
                    fifo_q.delete();
                    sent_q.delete();
                    for (int k = 0; k < LAT; k++) dpipe[k] = '0;
                end else begin
                    for (int k = LAT - 1; k > 0; k--) dpipe[k] = dpipe[k-1];
                    dpipe[0] = DW'($urandom);
                    if (rd_s && fifo_q.size() != 0) dpipe[0] = fifo_q.pop_front();
                    for (int k = 0; k < push_n; k++) begin
                        fifo_q.push_back(push_val + DW'(k));
                        sent_q.push_back(push_val + DW'(k));
                    end
                end
                fifo_empty = (fifo_q.size() == 0);
                fifo_dout  = dpipe[LAT-1];
            end
        end

        // Model: a word read in cycle c is visible from cycle c+LAT+1; reads allowed while
        // words outstanding (in flight + visible) stay below DEPTH.
        always @(negedge clk) begin
            fl_t           f;
            logic          exp_rd;
            logic [DW-1:0] w;
            cyc++;
            if (stat_clr) begin
                rel          = 0;
                st_rd[gi]    = 0;
                st_hs[gi]    = 0;
                st_vc[gi]    = 0;
                st_fv[gi]    = -1;
                st_lv[gi]    = -1;
                st_max[gi]   = 0;
                st_fd[gi]    = '0;
            end else begin
                rel++;
            end
            if (!arst_n) begin
                fl_q.delete();
                mb_q.delete();
                check(nm("rst_rd_en"), fifo_rd_en, 0);
                check(nm("rst_m_valid"), m_valid, 0);
                check(nm("rst_m_data"), m_data, 0);
                check(nm("rst_buf_level"), buf_level, 0);
                rd_s   = 1'b0;
                hold_v = 1'b0;
            end else begin
                while (fl_q.size() != 0 && fl_q[0].due <= cyc) begin
                    f = fl_q.pop_front();
                    mb_q.push_back(f.w);
                end
                exp_rd = !fifo_empty && (fl_q.size() + mb_q.size() < DEPTH);
                check(nm("rd_en"), fifo_rd_en, exp_rd);
                check(nm("rd_while_empty"), fifo_rd_en & fifo_empty, 0);
                check(nm("m_valid"), m_valid, mb_q.size() != 0);
                check(nm("buf_level"), buf_level, mb_q.size());
                if (mb_q.size() != 0) check(nm("m_data"), m_data, mb_q[0]);
                if (hold_v) begin
                    check(nm("hold_valid"), m_valid, 1);
                    check(nm("hold_data"), m_data, hold_d);
                end
                hold_v = m_valid && !m_ready;
                hold_d = m_data;
                if (m_valid) begin
                    st_vc[gi]++;
                    if (st_fv[gi] == -1) begin
                        st_fv[gi] = rel;
                        st_fd[gi] = m_data;
                    end
                    st_lv[gi] = rel;
                end
                if (m_valid && m_ready) begin
                    st_hs[gi]++;
                    w = (sent_q.size() != 0) ? sent_q.pop_front() : ~m_data;
                    check(nm("sb_order"), m_data, w);
                end
                if (mb_q.size() != 0 && m_ready) w = mb_q.pop_front();
                if (fifo_rd_en) st_rd[gi]++;
                if (fifo_rd_en && fifo_q.size() != 0) begin
                    f.w   = fifo_q[0];
                    f.due = cyc + LAT + 1;
                    fl_q.push_back(f);
                end
                rd_s = fifo_rd_en;
            end
            if (int'(buf_level) > st_max[gi]) st_max[gi] = int'(buf_level);
            st_pend[gi] = sent_q.size();
        end
    end

    task automatic tick(input int n, input logic [DW-1:0] v, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        push_n   = n;
        push_val = v;
        m_ready  = rdy;
        stat_clr = clr;
    endtask

    initial begin
        int            sent;
        int            n;
        logic [DW-1:0] seq;
        bit            busy;

        arst_n   = 1'b0;
        m_ready  = 1'b0;
        push_n   = 0;
        push_val = '0;
        stat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        tick(0, 8'h00, 1'b0, 1'b0);
        tick(0, 8'h00, 1'b0, 1'b0);

        // Single word
        tick(1, 8'hA5, 1'b1, 1'b1);
        repeat (10) tick(0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("single_rd_pulses_%0d", i), st_rd[i], 1);
            check($sformatf("single_latency_%0d", i), st_fv[i], exp_lat[i]);
            check($sformatf("single_valid_cycles_%0d", i), st_vc[i], 1);
            check($sformatf("single_data_%0d", i), st_fd[i], 8'hA5);
        end

        // Streaming 0..63
        tick(64, 8'h00, 1'b1, 1'b1);
        repeat (80) tick(0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("stream_rd_pulses_%0d", i), st_rd[i], 64);
            check($sformatf("stream_valid_cycles_%0d", i), st_vc[i], 64);
            check($sformatf("stream_no_gaps_%0d", i), st_lv[i] - st_fv[i] + 1, 64);
            check($sformatf("stream_latency_%0d", i), st_fv[i], exp_lat[i]);
            check($sformatf("stream_drained_%0d", i), st_pend[i], 0);
        end

        // Backpressure: 16 words, consumer stalled
        tick(16, 8'h00, 1'b0, 1'b1);
        repeat (20) tick(0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("bp_rd_pulses_%0d", i), st_rd[i], exp_depth[i]);
            check($sformatf("bp_level_%0d", i), lvl_all[i], exp_depth[i]);
            check($sformatf("bp_data_%0d", i), md_all[i], 8'h00);
            check($sformatf("bp_valid_%0d", i), mv_all[i], 1);
        end
        tick(0, 8'h00, 1'b1, 1'b1);
        repeat (30) tick(0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("bp_rel_rd_pulses_%0d", i), st_rd[i], 16 - exp_depth[i]);
            check($sformatf("bp_rel_handshakes_%0d", i), st_hs[i], 16);
            check($sformatf("bp_rel_first_%0d", i), st_fv[i], 0);
            check($sformatf("bp_rel_no_gaps_%0d", i), st_lv[i] - st_fv[i] + 1, 16);
            check($sformatf("bp_rel_drained_%0d", i), st_pend[i], 0);
        end

        // Random ready and bursty FIFO fill, 10000 words
        sent = 0;
        seq  = '0;
        tick(0, 8'h00, 1'b0, 1'b1);
        while (sent < 10000) begin
            if (((sent / 500) % 2) == 1) n = $urandom_range(0, 3);
            else                         n = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (sent + n > 10000) n = 10000 - sent;
            tick(n, seq, 1'($urandom_range(0, 1)), 1'b0);
            seq  = seq + DW'(n);
            sent = sent + n;
        end
        busy = 1'b1;
        for (int k = 0; k < 4000 && busy; k++) begin
            tick(0, 8'h00, 1'b1, 1'b0);
            busy = (mv_all != '0) || (rd_all != '0);
            for (int i = 0; i < NI; i++) if (st_pend[i] != 0) busy = 1'b1;
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rand_handshakes_%0d", i), st_hs[i], 10000);
            check($sformatf("rand_drained_%0d", i), st_pend[i], 0);
            check($sformatf("rand_level_bound_%0d", i), st_max[i] <= exp_depth[i], 1);
        end

        // Reset mid-burst
        tick(10, 8'h80, 1'b0, 1'b1);
        repeat (3) tick(0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_level_L2", lvl_all[1], 2);
        check("pre_reset_data_L2", md_all[1], 8'h80);
        arst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async_rst_valid_%0d", i), mv_all[i], 0);
            check($sformatf("async_rst_data_%0d", i), md_all[i], 0);
            check($sformatf("async_rst_level_%0d", i), lvl_all[i], 0);
            check($sformatf("async_rst_rd_en_%0d", i), rd_all[i], 0);
        end
        repeat (2) tick(0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1 arst_n = 1'b1;
        tick(0, 8'h00, 1'b0, 1'b0);
        tick(4, 8'h10, 1'b1, 1'b1);
        repeat (15) tick(0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("post_rst_handshakes_%0d", i), st_hs[i], 4);
            check($sformatf("post_rst_first_data_%0d", i), st_fd[i], 8'h10);
            check($sformatf("post_rst_drained_%0d", i), st_pend[i], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
